// File: rtl/vvp_acc.sv
// Bit-plane accumulator: combines per-plane signed vvp partial sums, MSB plane first,
// into a signed result held until the consumer takes it.
module vvp_acc #(
    parameter int N    = 64,
    parameter int SW   = $clog2(N) + 2,
    parameter int PMAX = 8,
    parameter int AW   = SW + PMAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SW-1:0]           in_s,
    input  logic [$clog2(PMAX):0]   cfg_planes,
    input  logic                    cfg_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           out_data
);

    // state | meaning
    // IDLE  | waiting for the first beat of a job
    // ACCUM | shifting in the remaining planes
    // HOLD  | result presented, waiting for out_ready
    localparam int PW = $clog2(PMAX) + 1;
    localparam logic [PW-1:0] PMAX_P = PW'(PMAX);
    localparam logic [PW-1:0] ONE_P  = PW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [PW-1:0] cnt;
    logic [PW-1:0] plen;

    logic [AW-1:0] s_ext;
    logic [AW-1:0] acc_first;
    logic [AW-1:0] acc_later;
    logic [PW-1:0] p_first;
    logic [PW-1:0] cnt_nxt;

    always_comb begin
        s_ext     = {{(AW-SW){in_s[SW-1]}}, in_s};
        // AW > SW, so negating the most negative plane sum cannot overflow
        acc_first = cfg_signed ? (~s_ext + {{(AW-1){1'b0}}, 1'b1}) : s_ext;
        acc_later = {acc[AW-2:0], 1'b0} + s_ext;
        p_first   = ((cfg_planes == '0) || (cfg_planes > PMAX_P)) ? PMAX_P : cfg_planes;
        cnt_nxt   = cnt + ONE_P;
    end

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            plen     <= '0;
            out_data <= '0;
        end else if (clr) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            plen     <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= acc_first;
                        cnt  <= ONE_P;
                        plen <= p_first;
                        if (p_first == ONE_P) begin
                            state    <= HOLD;
                            out_data <= acc_first;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_later;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == plen) begin
                            state    <= HOLD;
                            out_data <= acc_later;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vvp_acc.sv
// Self-checking bench for vvp_acc: directed cases plus randomized jobs against a
// weighted-sum reference model.
module tb_vvp_acc;

    localparam int N    = 64;
    localparam int SW   = 8;
    localparam int PMAX = 8;
    localparam int AW   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_s;
    logic [3:0]    cfg_planes;
    logic          cfg_signed;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    vvp_acc #(.N(N), .SW(SW), .PMAX(PMAX), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .cfg_planes (cfg_planes),
        .cfg_signed (cfg_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plane k (0 = MSB plane) carries weight 2^(P-1-k); a signed job negates the MSB weight.
    function automatic int model(input int p, input bit sg, input int s[8]);
        int r = 0;
        for (int k = 0; k < p; k++) begin
            int w = 1 << (p - 1 - k);
            if (k == 0 && sg) w = -w;
            r += w * s[k];
        end
        return r;
    endfunction

    task automatic do_job(input int cfgp, input bit sg, input int s[8],
                          input int gap_max, input int hold_cyc);
        int p;
        int r;
        p = (cfgp < 1 || cfgp > PMAX) ? PMAX : cfgp;
        r = model(p, sg, s);
        for (int k = 0; k < p; k++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) step();
            end
            in_valid   = 1'b1;
            in_s       = SW'(s[k]);
            cfg_planes = (k == 0) ? 4'(cfgp) : 4'($urandom);
            cfg_signed = (k == 0) ? sg : 1'($urandom);
            check("in_ready_beat", {15'd0, in_ready}, 16'd1);
            step();
            check("out_valid_after_beat", {15'd0, out_valid}, (k == p - 1) ? 16'd1 : 16'd0);
        end
        // offer beats during HOLD; they must be ignored
        in_valid = 1'b1;
        in_s     = SW'(7);
        check("out_data", out_data, AW'(r));
        check("in_ready_hold", {15'd0, in_ready}, 16'd0);
        for (int h = 0; h < hold_cyc; h++) begin
            step();
            check("out_valid_hold", {15'd0, out_valid}, 16'd1);
            check("in_ready_hold", {15'd0, in_ready}, 16'd0);
            check("out_data_hold", out_data, AW'(r));
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("out_valid_after_xfer", {15'd0, out_valid}, 16'd0);
        check("in_ready_after_xfer", {15'd0, in_ready}, 16'd1);
        check("out_data_kept", out_data, AW'(r));
    endtask

    initial begin
        int sv[8];
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_s = '0;
        cfg_planes = '0; cfg_signed = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", out_data, 16'd0);
        #11 rst_n = 1'b1;
        step();

        sv = '{1, 0, 1, 1, 0, 0, 0, 0};
        do_job(4, 1'b0, sv, 0, 0);
        check("unsigned4_const", out_data, 16'd11);

        sv = '{3, 1, 0, 0, 0, 0, 0, 0};
        do_job(2, 1'b1, sv, 0, 1);
        check("signed2_const", out_data, 16'hFFFB);

        sv = '{64, 64, 64, 64, 64, 64, 64, 64};
        do_job(8, 1'b0, sv, 0, 0);
        check("extreme_unsigned", out_data, 16'd16320);
        do_job(8, 1'b1, sv, 0, 0);
        check("extreme_signed", out_data, 16'hFFC0);

        sv = '{-128, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 1'b1, sv, 0, 0);
        check("neg_min", out_data, 16'd128);

        // backpressure: 7s offered for 5 cycles, then an independent job
        sv = '{2, 3, 0, 0, 0, 0, 0, 0};
        do_job(2, 1'b0, sv, 0, 5);
        sv = '{1, 1, 0, 0, 0, 0, 0, 0};
        do_job(2, 1'b0, sv, 0, 0);
        check("after_backpressure", out_data, 16'd3);

        // abort after 2 of 4 beats
        in_valid = 1'b1; cfg_planes = 4'd4; cfg_signed = 1'b0; in_s = 8'd5;
        step();
        step();
        in_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_out_valid", {15'd0, out_valid}, 16'd0);
        check("clr_in_ready", {15'd0, in_ready}, 16'd1);
        check("clr_out_data", out_data, 16'd0);

        sv = '{-7, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 1'b0, sv, 0, 0);
        check("one_plane_neg", out_data, 16'hFFF9);

        sv = '{1, 1, 1, 1, 1, 1, 1, 1};
        do_job(0, 1'b0, sv, 0, 0);
        check("clamp_zero", out_data, 16'd255);

        // clr discards a held result even with out_ready high
        in_valid = 1'b1; cfg_planes = 4'd1; cfg_signed = 1'b0; in_s = 8'd5;
        step();
        in_valid = 1'b0;
        check("hold_before_clr", {15'd0, out_valid}, 16'd1);
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b0;
        check("clr_hold_valid", {15'd0, out_valid}, 16'd0);
        check("clr_hold_data", out_data, 16'd0);

        // asynchronous reset while holding a result
        in_valid = 1'b1; cfg_planes = 4'd1; in_s = 8'd9;
        step();
        in_valid = 1'b0;
        check("hold_before_rst", out_data, 16'd9);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {15'd0, out_valid}, 16'd0);
        check("async_rst_data", out_data, 16'd0);
        check("async_rst_ready", {15'd0, in_ready}, 16'd1);
        #2 rst_n = 1'b1;
        step();
        sv = '{1, -2, 3, 0, 0, 0, 0, 0};
        do_job(3, 1'b1, sv, 0, 0);

        for (int j = 0; j < 40; j++) begin
            for (int k = 0; k < 8; k++) sv[k] = int'($urandom_range(0, 255)) - 128;
            do_job(int'($urandom_range(0, 10)), 1'($urandom), sv, 2, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
